// File: rtl/multicycle_control_unit.sv
// rtl/multicycle_control_unit.sv - multi-cycle RISC-V control FSM with memory handshakes, timeout trap and retire counter
module multicycle_control_unit #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 32
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             enable,
    input  logic [6:0]       opcode,
    input  logic             alu_zero,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             imem_req,
    output logic             dmem_req,
    output logic             ir_write,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic             mem_read,
    output logic             mem_write,
    output logic             reg_write,
    output logic [1:0]       wb_sel,
    output logic             branch,
    output logic             jump,
    output logic             busy,
    output logic             fault,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] retired
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;
    localparam logic [2:0] S_TRAP   = 3'd6;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    localparam int WAIT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    // Last wait-count value before the request expires; ready on that cycle still completes.
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    logic [6:0]        op_q;
    logic [WAIT_W-1:0] wait_cnt;
    logic [2:0]        state_next;
    logic              retire;
    logic              supported;
    logic              fetch_timeout;
    logic              mem_timeout;
    logic [2:0]        after_retire;

    always_comb begin
        supported     = (opcode == OP_R) || (opcode == OP_I) || (opcode == OP_BEQ) ||
                        (opcode == OP_JAL) || (opcode == OP_LOAD) || (opcode == OP_STORE);
        fetch_timeout = (TIMEOUT_CYCLES != 0) && !imem_ready && (wait_cnt == WAIT_LIMIT);
        mem_timeout   = (TIMEOUT_CYCLES != 0) && !dmem_ready && (wait_cnt == WAIT_LIMIT);
        after_retire  = enable ? S_FETCH : S_IDLE;
        state_next    = state;
        retire        = 1'b0;
        case (state)
            S_IDLE:   if (enable) state_next = S_FETCH;
            S_FETCH: begin
                if (imem_ready)         state_next = S_DECODE;
                else if (fetch_timeout) state_next = S_TRAP;
            end
            S_DECODE: state_next = supported ? S_EXEC : S_TRAP;
            S_EXEC: begin
                case (op_q)
                    OP_R, OP_I, OP_JAL: state_next = S_WB;
                    OP_LOAD, OP_STORE:  state_next = S_MEM;
                    OP_BEQ: begin
                        retire     = 1'b1;
                        state_next = after_retire;
                    end
                    default:            state_next = S_TRAP;
                endcase
            end
            S_MEM: begin
                if (dmem_ready) begin
                    if (op_q == OP_LOAD) begin
                        state_next = S_WB;
                    end else begin
                        retire     = 1'b1;
                        state_next = after_retire;
                    end
                end else if (mem_timeout) begin
                    state_next = S_TRAP;
                end
            end
            S_WB: begin
                retire     = 1'b1;
                state_next = after_retire;
            end
            S_TRAP:   state_next = S_TRAP;
            default:  state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state    <= S_IDLE;
            op_q     <= 7'd0;
            wait_cnt <= '0;
            retired  <= '0;
        end else begin
            state <= state_next;
            if (state == S_DECODE) op_q <= opcode;
            if ((state_next == S_FETCH && state != S_FETCH) || (state_next == S_MEM && state != S_MEM))
                wait_cnt <= '0;
            else if ((state == S_FETCH && !imem_ready) || (state == S_MEM && !dmem_ready))
                wait_cnt <= wait_cnt + WAIT_W'(1);
            if (retire) retired <= retired + CNT_W'(1);
        end
    end

    always_comb begin
        imem_req  = 1'b0;
        dmem_req  = 1'b0;
        ir_write  = 1'b0;
        pc_write  = 1'b0;
        pc_src    = 2'b00;
        alu_src_b = 2'b00;
        alu_op    = 2'b00;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        reg_write = 1'b0;
        wb_sel    = 2'b00;
        branch    = 1'b0;
        jump      = 1'b0;
        case (state)
            S_FETCH: begin
                imem_req = 1'b1;
                ir_write = imem_ready;
                pc_write = imem_ready;
            end
            S_EXEC: begin
                case (op_q)
                    OP_R: alu_op = 2'b10;
                    OP_I, OP_LOAD, OP_STORE: alu_src_b = 2'b01;
                    OP_BEQ: begin
                        alu_op   = 2'b01;
                        branch   = 1'b1;
                        pc_src   = 2'b01;
                        pc_write = alu_zero;
                    end
                    OP_JAL: begin
                        jump     = 1'b1;
                        pc_src   = 2'b10;
                        pc_write = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                dmem_req  = 1'b1;
                mem_read  = (op_q == OP_LOAD);
                mem_write = (op_q == OP_STORE);
            end
            S_WB: begin
                reg_write = 1'b1;
                if (op_q == OP_LOAD)     wb_sel = 2'b01;
                else if (op_q == OP_JAL) wb_sel = 2'b10;
            end
            default: ;
        endcase
        busy  = (state != S_IDLE) && (state != S_TRAP);
        fault = (state == S_TRAP);
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb/tb_multicycle_control_unit.sv - table-driven self-checking bench for multicycle_control_unit
module tb_multicycle_control_unit;

    localparam int CNT_W = 8;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BAD   = 7'b1111111;

    // {imem_req, dmem_req, ir_write, pc_write, pc_src, alu_src_b, alu_op, mem_read, mem_write, reg_write, wb_sel, branch, jump}
    localparam logic [16:0] P_NONE       = 17'd0;
    localparam logic [16:0] P_FETCH_RDY  = {1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0};
    localparam logic [16:0] P_FETCH_WAIT = {1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0};
    localparam logic [16:0] P_EX_R       = {1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b10, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0};
    localparam logic [16:0] P_EX_IMM     = {1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0};
    localparam logic [16:0] P_EX_BEQ_T   = {1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0};
    localparam logic [16:0] P_EX_BEQ_N   = {1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0};
    localparam logic [16:0] P_EX_JAL     = {1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1};
    localparam logic [16:0] P_MEM_RD     = {1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0};
    localparam logic [16:0] P_MEM_WR     = {1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0};
    localparam logic [16:0] P_WB_ALU     = {1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0};
    localparam logic [16:0] P_WB_MEM     = {1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0};
    localparam logic [16:0] P_WB_LINK    = {1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0};

    typedef struct {
        logic        en;
        logic [6:0]  op;
        logic        zero;
        logic        ir;
        logic        dr;
        logic [2:0]  st;
        logic [16:0] outs;
        logic        ret;
    } vec_t;

    logic             clk = 1'b0;
    logic             arst = 1'b1;
    logic             enable = 1'b0;
    logic [6:0]       opcode = 7'd0;
    logic             alu_zero = 1'b0;
    logic             imem_ready = 1'b0;
    logic             dmem_ready = 1'b0;
    logic             imem_req, dmem_req, ir_write, pc_write;
    logic [1:0]       pc_src, alu_src_b, alu_op, wb_sel;
    logic             mem_read, mem_write, reg_write, branch, jump, busy, fault;
    logic [2:0]       state;
    logic [CNT_W-1:0] retired;
    logic [16:0]      outs_act;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   exp_ret = 0;
    vec_t vecs[$];

    assign outs_act = {imem_req, dmem_req, ir_write, pc_write, pc_src, alu_src_b, alu_op,
                       mem_read, mem_write, reg_write, wb_sel, branch, jump};

    always #5 clk = ~clk;

    multicycle_control_unit #(.TIMEOUT_CYCLES(4), .CNT_W(CNT_W)) dut (
        .clk(clk), .arst(arst), .enable(enable), .opcode(opcode), .alu_zero(alu_zero),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready), .imem_req(imem_req), .dmem_req(dmem_req),
        .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
        .wb_sel(wb_sel), .branch(branch), .jump(jump), .busy(busy), .fault(fault),
        .state(state), .retired(retired)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic add(input logic en, input logic [6:0] op, input logic zero, input logic ir,
                       input logic dr, input logic [2:0] st, input logic [16:0] outs, input logic ret);
        vec_t v;
        v.en = en; v.op = op; v.zero = zero; v.ir = ir; v.dr = dr;
        v.st = st; v.outs = outs; v.ret = ret;
        vecs.push_back(v);
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        arst = 1'b1; enable = 1'b0; opcode = 7'd0; alu_zero = 1'b0;
        imem_ready = 1'b0; dmem_ready = 1'b0;
        #1;
        check("reset_state", 32'(state), 32'd0);
        check("reset_outs", 32'(outs_act), 32'(P_NONE));
        check("reset_retired", 32'(retired), 32'd0);
        check("reset_busy_fault", {30'd0, busy, fault}, 32'd0);
        exp_ret = 0;
        @(negedge clk);
        arst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // R, I, LOAD (3 wait states), STORE, BEQ taken/not-taken, JAL, then a fetch that is ready on its last allowed cycle
        add(0, 7'd0,     0, 1, 1, 3'd0, P_NONE,       0);
        add(1, 7'd0,     0, 1, 1, 3'd0, P_NONE,       0);
        add(1, 7'd0,     0, 1, 1, 3'd1, P_FETCH_RDY,  0);
        add(1, OP_R,     0, 1, 1, 3'd2, P_NONE,       0);
        add(1, OP_BAD,   0, 1, 1, 3'd3, P_EX_R,       0);
        add(1, 7'd0,     0, 1, 1, 3'd5, P_WB_ALU,     1);
        add(1, 7'd0,     0, 1, 1, 3'd1, P_FETCH_RDY,  0);
        add(1, OP_I,     0, 1, 1, 3'd2, P_NONE,       0);
        add(1, 7'd0,     0, 1, 1, 3'd3, P_EX_IMM,     0);
        add(1, 7'd0,     0, 1, 1, 3'd5, P_WB_ALU,     1);
        add(1, 7'd0,     0, 1, 1, 3'd1, P_FETCH_RDY,  0);
        add(1, OP_LOAD,  0, 1, 1, 3'd2, P_NONE,       0);
        add(1, 7'd0,     0, 1, 0, 3'd3, P_EX_IMM,     0);
        add(1, 7'd0,     0, 1, 0, 3'd4, P_MEM_RD,     0);
        add(1, 7'd0,     0, 1, 0, 3'd4, P_MEM_RD,     0);
        add(1, 7'd0,     0, 1, 0, 3'd4, P_MEM_RD,     0);
        add(1, 7'd0,     0, 1, 1, 3'd4, P_MEM_RD,     0);
        add(1, 7'd0,     0, 1, 1, 3'd5, P_WB_MEM,     1);
        add(1, 7'd0,     0, 1, 1, 3'd1, P_FETCH_RDY,  0);
        add(1, OP_STORE, 0, 1, 1, 3'd2, P_NONE,       0);
        add(1, 7'd0,     0, 1, 1, 3'd3, P_EX_IMM,     0);
        add(1, 7'd0,     0, 1, 1, 3'd4, P_MEM_WR,     1);
        add(1, 7'd0,     0, 1, 1, 3'd1, P_FETCH_RDY,  0);
        add(1, OP_BEQ,   0, 1, 1, 3'd2, P_NONE,       0);
        add(1, 7'd0,     1, 1, 1, 3'd3, P_EX_BEQ_T,   1);
        add(1, 7'd0,     0, 1, 1, 3'd1, P_FETCH_RDY,  0);
        add(1, OP_BEQ,   0, 1, 1, 3'd2, P_NONE,       0);
        add(1, 7'd0,     0, 1, 1, 3'd3, P_EX_BEQ_N,   1);
        add(1, 7'd0,     0, 1, 1, 3'd1, P_FETCH_RDY,  0);
        add(1, OP_JAL,   0, 1, 1, 3'd2, P_NONE,       0);
        add(1, 7'd0,     0, 1, 1, 3'd3, P_EX_JAL,     0);
        add(0, 7'd0,     0, 1, 1, 3'd5, P_WB_LINK,    1);
        add(0, 7'd0,     0, 1, 1, 3'd0, P_NONE,       0);
        add(1, 7'd0,     0, 0, 1, 3'd0, P_NONE,       0);
        add(1, 7'd0,     0, 0, 1, 3'd1, P_FETCH_WAIT, 0);
        add(1, 7'd0,     0, 0, 1, 3'd1, P_FETCH_WAIT, 0);
        add(1, 7'd0,     0, 0, 1, 3'd1, P_FETCH_WAIT, 0);
        add(1, 7'd0,     0, 1, 1, 3'd1, P_FETCH_RDY,  0);
        add(0, OP_R,     0, 1, 1, 3'd2, P_NONE,       0);
        add(0, 7'd0,     0, 1, 1, 3'd3, P_EX_R,       0);
        add(0, 7'd0,     0, 1, 1, 3'd5, P_WB_ALU,     1);
        add(0, 7'd0,     0, 1, 1, 3'd0, P_NONE,       0);

        do_reset();
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            enable = vecs[i].en; opcode = vecs[i].op; alu_zero = vecs[i].zero;
            imem_ready = vecs[i].ir; dmem_ready = vecs[i].dr;
            #1;
            check($sformatf("vec%0d_state", i), 32'(state), 32'(vecs[i].st));
            check($sformatf("vec%0d_outs", i), 32'(outs_act), 32'(vecs[i].outs));
            check($sformatf("vec%0d_retired", i), 32'(retired), 32'(exp_ret));
            check($sformatf("vec%0d_busy_fault", i), {30'd0, busy, fault},
                  {30'd0, (vecs[i].st != 3'd0 && vecs[i].st != 3'd6), vecs[i].st == 3'd6});
            if (vecs[i].ret) exp_ret = (exp_ret + 1) % (1 << CNT_W);
        end

        // Fetch never completes: four waiting FETCH cycles, then sticky TRAP until arst
        do_reset();
        enable = 1'b1; imem_ready = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            sample();
            check($sformatf("fto_fetch%0d_state", k), 32'(state), 32'd1);
            check($sformatf("fto_fetch%0d_irw", k), {31'd0, ir_write | pc_write}, 32'd0);
        end
        sample();
        check("fto_trap_state", 32'(state), 32'd6);
        check("fto_trap_busy_fault", {30'd0, busy, fault}, 32'd1);
        check("fto_trap_outs", 32'(outs_act), 32'(P_NONE));
        imem_ready = 1'b1; dmem_ready = 1'b1; opcode = OP_R;
        for (int k = 0; k < 20; k++) begin
            sample();
            check($sformatf("trap_hold%0d", k), {21'd0, state, retired}, {21'd0, 3'd6, 8'd0});
        end
        arst = 1'b1;
        #1;
        check("trap_arst_state", 32'(state), 32'd0);
        check("trap_arst_fault", {31'd0, fault}, 32'd0);
        @(negedge clk);
        arst = 1'b0;

        // Unsupported opcode traps right after DECODE
        do_reset();
        enable = 1'b1; imem_ready = 1'b1; opcode = OP_BAD;
        sample(); check("bad_fetch", 32'(state), 32'd1);
        sample(); check("bad_decode", 32'(state), 32'd2);
        sample(); check("bad_trap", 32'(state), 32'd6);
        check("bad_fault", {31'd0, fault}, 32'd1);

        // Data access never completes: four MEM cycles with mem_read held, then TRAP
        do_reset();
        enable = 1'b1; imem_ready = 1'b1; dmem_ready = 1'b0; opcode = OP_LOAD;
        sample(); sample(); sample();
        check("mto_exec", 32'(state), 32'd3);
        for (int k = 1; k <= 4; k++) begin
            sample();
            check($sformatf("mto_mem%0d", k), {15'd0, state, outs_act}, {15'd0, 3'd4, P_MEM_RD});
        end
        sample();
        check("mto_trap", 32'(state), 32'd6);
        check("mto_no_reg_write", {31'd0, reg_write}, 32'd0);

        // Reset in the middle of a STORE drops the write strobe at once
        do_reset();
        enable = 1'b1; imem_ready = 1'b1; dmem_ready = 1'b0; opcode = OP_STORE;
        sample(); sample(); sample(); sample();
        check("mid_mem_write", {15'd0, state, outs_act}, {15'd0, 3'd4, P_MEM_WR});
        arst = 1'b1;
        #1;
        check("mid_arst_state", 32'(state), 32'd0);
        check("mid_arst_outs", 32'(outs_act), 32'(P_NONE));
        sample();
        check("mid_arst_hold", 32'(state), 32'd0);
        arst = 1'b0;

        // Retire counter wraps after 256 back-to-back BEQs
        do_reset();
        enable = 1'b1; imem_ready = 1'b1; opcode = OP_BEQ; alu_zero = 1'b0;
        repeat (1 + 3 * 255) @(posedge clk);
        sample();
        check("wrap_255", {21'd0, state, retired}, {21'd0, 3'd1, 8'd255});
        repeat (3) @(posedge clk);
        sample();
        check("wrap_0", {21'd0, state, retired}, {21'd0, 3'd1, 8'd0});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Registered, multi-cycle successor to the single-cycle RISC-V control decoder.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states and drives the datapath enables for each step.
- Supports the R, I, BEQ, JAL (with link write-back), LOAD and STORE opcodes.
- Adds valid/ready handshakes to instruction and data memories with variable wait states, a bus-timeout trap and a retired-instruction counter.

Parameters:
- TIMEOUT_CYCLES, 16, max cycles a memory request may wait for ready before trapping; 0 disables the timeout.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  clock, rising edge.
- arst  in  1  asynchronous reset, active-high.
- enable  in  1  run request; sampled in IDLE, WB, and at the end of BEQ and STORE.
- opcode  in  7  instruction[6:0] from the IR; valid in DECODE.
- alu_zero  in  1  ALU zero flag; valid in EXEC.
- imem_ready  in  1  instruction memory completes the fetch.
- dmem_ready  in  1  data memory completes the access.
- imem_req  out  1  fetch request.
- dmem_req  out  1  data access request.
- ir_write  out  1  load the IR.
- pc_write  out  1  update the PC.
- pc_src  out  2  00 = PC+4, 01 = branch target, 10 = jump target.
- alu_src_b  out  2  00 = register, 01 = immediate.
- alu_op  out  2  00 = add, 01 = sub, 10 = R-type.
- mem_read  out  1  data memory read strobe.
- mem_write  out  1  data memory write strobe.
- reg_write  out  1  register file write.
- wb_sel  out  2  00 = ALU, 01 = memory, 10 = PC+4 (link).
- branch  out  1  BEQ in EXEC.
- jump  out  1  JAL in EXEC.
- busy  out  1  state is neither IDLE nor TRAP.
- fault  out  1  state is TRAP.
- state  out  3  IDLE = 0, FETCH = 1, DECODE = 2, EXEC = 3, MEM = 4, WB = 5, TRAP = 6.
- retired  out  CNT_W  count of completed instructions.

Behaviour:
- Registers: state, latched opcode, wait counter and retired count. All other outputs are decoded combinationally from (state, latched opcode).
- Reset: arst forces state = IDLE, latched opcode = 0, wait counter = 0, retired = 0. In IDLE every output is 0. Reset mid-instruction aborts immediately, with no write strobes on the next edge.
- IDLE: go to FETCH when enable = 1.
- FETCH:
  - imem_req = 1 until imem_ready.
  - On the ready cycle: ir_write = 1, pc_write = 1, pc_src = 00, then go to DECODE.
- DECODE:
  - Latch opcode.
  - Supported opcodes are 0110011, 0010011, 1100011, 1101111, 0000011 and 0100011. Any of these goes to EXEC; anything else goes to TRAP.
- EXEC:
  - R: alu_op = 10, alu_src_b = 00, then WB.
  - I: alu_op = 00, alu_src_b = 01, then WB.
  - LOAD/STORE: alu_op = 00, alu_src_b = 01, then MEM.
  - BEQ: alu_op = 01, branch = 1, pc_src = 01, pc_write = alu_zero. Retire, then go to FETCH if enable, else IDLE.
  - JAL: jump = 1, pc_src = 10, pc_write = 1, then WB.
- MEM:
  - dmem_req = 1, plus mem_read (LOAD) or mem_write (STORE), all held until dmem_ready.
  - On ready: LOAD goes to WB. STORE retires, then goes to FETCH if enable, else IDLE.
- WB:
  - reg_write = 1 for exactly one cycle.
  - wb_sel = 01 for LOAD, 10 for JAL, 00 otherwise.
  - Retire, then go to FETCH if enable, else IDLE.
- Retire: retired increments by 1 on the completing edge and wraps modulo 2^CNT_W.
- Latency with zero wait states (cycles from the FETCH entry edge): BEQ 3, R/I/JAL/STORE 4, LOAD 5. Each wait cycle adds 1.
- Wait counter:
  - Clears on entry to FETCH and MEM.
  - Increments each cycle the request is held and ready = 0.
  - If it reaches TIMEOUT_CYCLES with ready still 0, go to TRAP; no ir_write or pc_write occurs.
  - A ready arriving on the same cycle as the limit wins (normal completion).
- TRAP: sticky until arst. All strobes are 0, fault = 1, busy = 0, retired is frozen.
- enable = 0 mid-instruction does not abort; the instruction completes, then the FSM returns to IDLE.
- Opcode changes after DECODE are ignored.

Test Plan:
- Reset, enable = 1, R-type (0110011), ready held high -> states 1,2,3,5,1; reg_write high only in WB; alu_op = 10; retired = 1 after 4 cycles.
- LOAD with dmem_ready delayed 3 cycles -> MEM lasts 4 cycles with mem_read held; WB has wb_sel = 01; total 8 cycles.
- BEQ with alu_zero = 1, then again with alu_zero = 0 -> pc_write = 1 / pc_src = 01 in EXEC, then pc_write = 0; no reg_write; each takes 3 cycles.
- JAL -> EXEC jump = 1, pc_src = 10, pc_write = 1; WB has reg_write = 1, wb_sel = 10.
- Opcode 1111111 -> TRAP at the cycle after DECODE; fault = 1; state stays 6 for 20 cycles despite enable; arst returns state to 0.
- TIMEOUT_CYCLES = 4, imem_ready held 0 -> TRAP after 4 wait cycles with no ir_write. Repeat with ready asserted exactly on the 4th cycle -> normal DECODE.
